wb_select_stage: RTL

WB_SELECT_STAGE -- requirements
Module: wb_select_stage

---
 rtl/wb_select_stage_pkg.sv | 24 ++
 rtl/wb_src_mux.sv | 26 ++
 rtl/wb_select_stage.sv | 111 +++++++++++
 3 files changed

// File: rtl/wb_select_stage_pkg.sv
// Shared definitions for the writeback select stage.
// Holds the writeback source indices, the x0 register index and the
// packed control payload kept in the stage register.
package wb_select_stage_pkg;

   localparam int unsigned REG_IDX_W = 5;

   // Writeback source indices; higher indices are spare
   localparam int unsigned SRC_LINK  = 0;  // JAL/JALR link address
   localparam int unsigned SRC_AUIPC = 1;  // AUIPC result
   localparam int unsigned SRC_LUI   = 2;  // LUI immediate
   localparam int unsigned SRC_MEM   = 3;  // memory / ALU result

   // Architectural zero register
   localparam logic [REG_IDX_W-1:0] REG_X0 = REG_IDX_W'(0);

   // Control half of a stage entry
   typedef struct packed {
      logic                 valid;
      logic                 we;
      logic [REG_IDX_W-1:0] rd;
   } wb_ctl_t;

endpackage : wb_select_stage_pkg

// File: rtl/wb_src_mux.sv
// Combinational writeback source selector.
// Ports:
//   sel_i      - source index
//   src_data_i - flattened sources, source k at [k*WIDTH +: WIDTH]
//   data_c_o   - selected source, zero when sel_i >= NUM_SRC
module wb_src_mux #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned NUM_SRC = 4,
   parameter int unsigned SEL_W   = 2
) (
   input  logic [SEL_W-1:0]         sel_i,
   input  logic [NUM_SRC*WIDTH-1:0] src_data_i,
   output logic [WIDTH-1:0]         data_c_o
);

   // Indices past the last source match nothing and fall through to zero
   always_comb begin
      data_c_o = '0;
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         if (32'(sel_i) == k) begin
            data_c_o = src_data_i[k*WIDTH +: WIDTH];
         end
      end
   end

endmodule : wb_src_mux

// File: rtl/wb_select_stage.sv
// Writeback select stage: picks one of NUM_SRC candidate results, registers
// it with its destination, offers forwarding hits and counts commits.
// Ports:
//   clk, rst             - clock, async active-high reset
//   in_valid/sel/src_data/in_rd/in_we - incoming writeback candidate
//   stall, flush         - hold / invalidate the stage entry
//   rs1, rs2             - source indices checked for forwarding
//   out_valid/out_data/out_rd/out_we  - registered stage entry
//   fwd1_hit, fwd2_hit   - combinational forwarding matches
//   sel_err              - sticky out-of-range select flag
//   wb_count             - committed register-write counter
module wb_select_stage
   import wb_select_stage_pkg::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned NUM_SRC = 4,
   parameter int unsigned SEL_W   = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [SEL_W-1:0]         sel,
   input  logic [NUM_SRC*WIDTH-1:0] src_data,
   input  logic [REG_IDX_W-1:0]     in_rd,
   input  logic                     in_we,
   input  logic                     stall,
   input  logic                     flush,
   input  logic [REG_IDX_W-1:0]     rs1,
   input  logic [REG_IDX_W-1:0]     rs2,
   output logic                     out_valid,
   output logic [WIDTH-1:0]         out_data,
   output logic [REG_IDX_W-1:0]     out_rd,
   output logic                     out_we,
   output logic                     fwd1_hit,
   output logic                     fwd2_hit,
   output logic                     sel_err,
   output logic [31:0]              wb_count
);

   wb_ctl_t          ctl_q,     ctl_d;
   logic [WIDTH-1:0] data_q,    data_d;
   logic             sel_err_q, sel_err_d;
   logic [31:0]      cnt_q,     cnt_d;

   logic [WIDTH-1:0] mux_data_c;
   logic             sel_oob_c;
   logic             commit_c;

   wb_src_mux #(
      .WIDTH   (WIDTH),
      .NUM_SRC (NUM_SRC),
      .SEL_W   (SEL_W)
   ) u_src_mux (
      .sel_i      (sel),
      .src_data_i (src_data),
      .data_c_o   (mux_data_c)
   );

   assign sel_oob_c = (32'(sel) >= NUM_SRC);

   // The held entry retires on any non-stalled edge, including a flush edge
   assign commit_c = ctl_q.valid & ctl_q.we & ~stall;

   // Next-state: flush beats stall beats load
   always_comb begin
      ctl_d     = ctl_q;
      data_d    = data_q;
      sel_err_d = sel_err_q;
      cnt_d     = commit_c ? cnt_q + 32'd1 : cnt_q;

      if (flush) begin
         ctl_d.valid = 1'b0;
         ctl_d.we    = 1'b0;
      end else if (!stall) begin
         ctl_d.valid = in_valid;
         ctl_d.rd    = in_rd;
         ctl_d.we    = in_we & in_valid & (in_rd != REG_X0);
         data_d      = mux_data_c;
         if (in_valid && sel_oob_c) begin
            sel_err_d = 1'b1;
         end
      end
   end

   // Stage register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctl_q     <= '0;
         data_q    <= '0;
         sel_err_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         ctl_q     <= ctl_d;
         data_q    <= data_d;
         sel_err_q <= sel_err_d;
         cnt_q     <= cnt_d;
      end
   end

   assign out_valid = ctl_q.valid;
   assign out_data  = data_q;
   assign out_rd    = ctl_q.rd;
   assign out_we    = ctl_q.we;
   assign sel_err   = sel_err_q;
   assign wb_count  = cnt_q;

   // Forwarding never matches x0
   assign fwd1_hit = ctl_q.valid & ctl_q.we & (ctl_q.rd == rs1) & (rs1 != REG_X0);
   assign fwd2_hit = ctl_q.valid & ctl_q.we & (ctl_q.rd == rs2) & (rs2 != REG_X0);

endmodule : wb_select_stage
